// File: rtl/pifo_pkg.sv
// pifo_pkg: shared widths and entry type for the PIFO ingress path
package pifo_pkg;
  localparam int DEF_RANK_WIDTH = 10;
  localparam int DEF_META_WIDTH = 20;
  localparam int DEF_L2_DEPTH = 4;
  localparam int DEF_CNT_WIDTH = 32;
  typedef struct packed {
    logic [DEF_RANK_WIDTH-1:0] rank;
    logic [DEF_META_WIDTH-1:0] meta;
  } entry_t;
endpackage

// File: rtl/pifo_ingress_buffer_if.sv
// pifo_ingress_buffer_if: valid/ready request channel carrying (rank, meta)
interface pifo_ingress_buffer_if
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = DEF_RANK_WIDTH,
  parameter int META_WIDTH = DEF_META_WIDTH
) ();
  logic valid;
  logic ready;
  logic [RANK_WIDTH-1:0] rank;
  logic [META_WIDTH-1:0] meta;
  modport master (output valid, rank, meta, input ready);
  modport slave (input valid, rank, meta, output ready);
endinterface

// File: rtl/pifo_sync_fifo.sv
// pifo_sync_fifo: single-clock show-ahead FIFO with registered entry count
module pifo_sync_fifo
  import pifo_pkg::*;
#(
  parameter int W = DEF_RANK_WIDTH + DEF_META_WIDTH,
  parameter int L2 = DEF_L2_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [L2:0]  count
);
  logic [W-1:0] mem [2**L2];
  logic [L2-1:0] wp, rp;
  assign full = count == (L2+1)'(2**L2);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + L2'(1);
      if (pop) rp <= rp + L2'(1);
      count <= count + (L2+1)'(push) - (L2+1)'(pop);
    end
  end
endmodule

// File: rtl/pifo_ingress_buffer.sv
// pifo_ingress_buffer: elastic FIFO that replays insert requests into pifo_top when a skip list is free
module pifo_ingress_buffer
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = DEF_RANK_WIDTH,
  parameter int META_WIDTH = DEF_META_WIDTH,
  parameter int L2_DEPTH = DEF_L2_DEPTH,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  pifo_ingress_buffer_if.slave  s,
  output logic                  pifo_insert,
  output logic [RANK_WIDTH-1:0] pifo_rank,
  output logic [META_WIDTH-1:0] pifo_meta,
  input  logic                  pifo_busy,
  input  logic                  pifo_full,
  output logic [L2_DEPTH:0]     occupancy,
  output logic [CNT_WIDTH-1:0]  enq_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);
  logic full, empty, push, pop, drop;
  assign s.ready = !rst && ((DROP_ON_FULL != 0) || !full);
  assign push = s.valid && s.ready && !full;
  assign drop = (DROP_ON_FULL != 0) && s.valid && full && !rst;
  assign pop = !empty && !pifo_busy && !pifo_full && !rst;
  assign pifo_insert = pop;
  pifo_sync_fifo #(.W(RANK_WIDTH + META_WIDTH), .L2(L2_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({s.rank, s.meta}),
    .dout({pifo_rank, pifo_meta}),
    .full(full),
    .empty(empty),
    .count(occupancy)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      enq_count <= '0;
      drop_count <= '0;
    end else begin
      if (pop && !(&enq_count)) enq_count <= enq_count + CNT_WIDTH'(1);
      if (drop && !(&drop_count)) drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_pifo_ingress_buffer.sv
// tb_pifo_ingress_buffer: stalling and dropping instances checked cycle by cycle against queue models
module tb_pifo_ingress_buffer;
  import pifo_pkg::*;
  logic clk = 0, rst = 1, busy = 0, pfull = 0;
  logic valid = 0;
  logic [9:0] rank = 0;
  logic [19:0] meta = 0;
  logic ins0, ins1;
  logic [9:0] rk0, rk1;
  logic [19:0] mt0, mt1;
  logic [4:0] occ0, occ1;
  logic [31:0] enq0, drp0;
  logic [3:0] enq1, drp1;
  int cmp = 0, errs = 0;
  logic [29:0] q0[$], q1[$];
  longint m_enq0 = 0, m_drp0 = 0, m_enq1 = 0, m_drp1 = 0;

  always #5 clk = ~clk;

  pifo_ingress_buffer_if #(.RANK_WIDTH(10), .META_WIDTH(20)) s0 ();
  pifo_ingress_buffer_if #(.RANK_WIDTH(10), .META_WIDTH(20)) s1 ();
  assign s0.valid = valid;
  assign s0.rank = rank;
  assign s0.meta = meta;
  assign s1.valid = valid;
  assign s1.rank = rank;
  assign s1.meta = meta;

  pifo_ingress_buffer #(.DROP_ON_FULL(0), .CNT_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst), .s(s0), .pifo_insert(ins0), .pifo_rank(rk0), .pifo_meta(mt0),
    .pifo_busy(busy), .pifo_full(pfull), .occupancy(occ0), .enq_count(enq0), .drop_count(drp0));
  pifo_ingress_buffer #(.DROP_ON_FULL(1), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .s(s1), .pifo_insert(ins1), .pifo_rank(rk1), .pifo_meta(mt1),
    .pifo_busy(busy), .pifo_full(pfull), .occupancy(occ1), .enq_count(enq1), .drop_count(drp1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return v >= mx ? mx : v + 1;
  endfunction

  task automatic cyc(input logic v, input logic [9:0] r, input logic [19:0] m,
                     input logic b, input logic f, input logic rs);
    logic [29:0] h0, h1;
    bit i0, i1;
    valid = v; rank = r; meta = m; busy = b; pfull = f; rst = rs;
    @(negedge clk);
    h0 = q0.size() > 0 ? q0[0] : 30'd0;
    h1 = q1.size() > 0 ? q1[0] : 30'd0;
    i0 = q0.size() > 0 && !b && !f && !rs;
    i1 = q1.size() > 0 && !b && !f && !rs;
    chk("insert0", 64'(ins0), 64'(i0));
    chk("rank0", 64'(rk0), 64'(h0[29:20]));
    chk("meta0", 64'(mt0), 64'(h0[19:0]));
    chk("ready0", 64'(s0.ready), 64'(!rs && q0.size() < 16));
    chk("occ0", 64'(occ0), 64'(q0.size()));
    chk("enq0", 64'(enq0), 64'(m_enq0));
    chk("drop0", 64'(drp0), 64'(m_drp0));
    chk("insert1", 64'(ins1), 64'(i1));
    chk("rank1", 64'(rk1), 64'(h1[29:20]));
    chk("meta1", 64'(mt1), 64'(h1[19:0]));
    chk("ready1", 64'(s1.ready), 64'(!rs));
    chk("occ1", 64'(occ1), 64'(q1.size()));
    chk("enq1", 64'(enq1), 64'(m_enq1));
    chk("drop1", 64'(drp1), 64'(m_drp1));
    @(posedge clk);
    if (rs) begin
      q0.delete(); q1.delete();
      m_enq0 = 0; m_drp0 = 0; m_enq1 = 0; m_drp1 = 0;
    end else begin
      if (v && q0.size() < 16) q0.push_back({r, m});
      if (v && q1.size() < 16) q1.push_back({r, m});
      else if (v) m_drp1 = sat(m_drp1, 15);
      if (i0) begin void'(q0.pop_front()); m_enq0 = sat(m_enq0, 32'hFFFF_FFFF); end
      if (i1) begin void'(q1.pop_front()); m_enq1 = sat(m_enq1, 15); end
    end
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    // single request, one-cycle latency
    cyc(1, 10'd5, 20'hABCDE, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    // fill past depth while busy, then drain in order
    for (int i = 0; i < 20; i++) cyc(1, 10'(i), 20'(i * 3), 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
    // busy toggling every cycle under continuous arrivals
    for (int i = 0; i < 120; i++) cyc(1, 10'($urandom), 20'($urandom), 1'(i % 2), 0, 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1'(i % 2), 0, 0);
    // pifo_full holds three entries
    for (int i = 0; i < 3; i++) cyc(1, 10'(100 + i), 20'(i), 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
    // reset with eight entries buffered
    for (int i = 0; i < 8; i++) cyc(1, 10'(200 + i), 20'(i), 1, 0, 0);
    cyc(1, 10'd300, 20'd1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    // random traffic; long enough to saturate the 4-bit counters
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 10'($urandom), 20'($urandom),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 150) == 0));
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
